// File: rtl/gate_phase_stream.sv
// gate_phase_stream: phase-rotation gate on a streamed state vector.
// Three-stage multiply / add-round / shift-clamp pipeline with frame FSM.
module gate_phase_stream #(
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = 15,
  parameter int NUM_QUBITS = 4,
  parameter int ROUND      = 1,
  parameter int SAT        = 1,
  localparam int QW = (NUM_QUBITS > 1) ? $clog2(NUM_QUBITS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_load,
  input  logic [QW-1:0]     cfg_target,
  input  logic [QW-1:0]     cfg_ctrl,
  input  logic              cfg_ctrl_en,
  input  logic [DATA_W-1:0] cfg_cos,
  input  logic [DATA_W-1:0] cfg_sin,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int PW = 2 * DATA_W;
  localparam int SW = 2 * DATA_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [NUM_QUBITS-1:0] IDX_LAST = '1;

  localparam logic [SW-1:0] RNDV =
    (ROUND != 0) ? SW'((64'd1 << FRAC_W) >> 1) : '0;
  localparam logic [DATA_W-1:0] COS_ID =
    DATA_W'((64'd1 << FRAC_W) - 64'd1);
  localparam logic [DATA_W-1:0] MAXV =
    {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MINV =
    {1'b1, {(DATA_W-1){1'b0}}};

  // Bit b of the beat index; qubits beyond the frame read as 0.
  function automatic logic sel(
    input logic [NUM_QUBITS-1:0] v,
    input logic [QW-1:0]         b
  );
    sel = 1'b0;
    for (int i = 0; i < NUM_QUBITS; i++)
      if (b == QW'(i)) sel = v[i];
  endfunction

  // Drop fraction bits, then clamp or wrap into DATA_W.
  function automatic logic [DATA_W-1:0] fit(
    input logic signed [SW-1:0] v
  );
    logic signed [SW-1:0] sh;
    sh = v >>> FRAC_W;
    if (SAT != 0 &&
        sh != {{(SW-DATA_W){sh[DATA_W-1]}}, sh[DATA_W-1:0]})
      fit = sh[SW-1] ? MINV : MAXV;
    else
      fit = sh[DATA_W-1:0];
  endfunction

  logic [1:0]            state;
  logic [NUM_QUBITS-1:0] idx;
  logic                  live;

  logic [QW-1:0]            c_tgt, c_ctl;
  logic                     c_cen;
  logic signed [DATA_W-1:0] c_cos, c_sin;

  logic [QW-1:0]            e_tgt, e_ctl;
  logic                     e_cen;
  logic signed [DATA_W-1:0] e_cos, e_sin;

  logic adv, acc, load_ok, apply, xfer_last;

  logic              s1_v, s1_ap, s1_last;
  logic [DATA_W-1:0] s1_re, s1_im;
  logic signed [PW-1:0] s1_rc, s1_is, s1_rs, s1_ic;

  logic              s2_v, s2_ap, s2_last;
  logic [DATA_W-1:0] s2_re, s2_im;
  logic signed [SW-1:0] s2_sr, s2_si;

  assign adv       = ~out_valid | out_ready;
  assign in_ready  = live & adv & (state != S_DRAIN);
  assign acc       = in_valid & in_ready;
  assign load_ok   = cfg_load & (state == S_IDLE);
  assign xfer_last = out_valid & out_ready & out_last;
  assign busy      = (state != S_IDLE);

  // Config seen by the current beat: a load in IDLE takes effect at once.
  always_comb begin
    e_tgt = c_tgt;
    e_ctl = c_ctl;
    e_cen = c_cen;
    e_cos = c_cos;
    e_sin = c_sin;
    if (load_ok) begin
      e_tgt = cfg_target;
      e_ctl = cfg_ctrl;
      e_cen = cfg_ctrl_en;
      e_cos = cfg_cos;
      e_sin = cfg_sin;
    end
    apply = sel(idx, e_tgt) & (~e_cen | sel(idx, e_ctl));
  end

  // Config registers, identity rotation after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_tgt <= '0;
      c_ctl <= '0;
      c_cen <= 1'b0;
      c_cos <= COS_ID;
      c_sin <= '0;
    end else if (load_ok) begin
      c_tgt <= cfg_target;
      c_ctl <= cfg_ctrl;
      c_cen <= cfg_ctrl_en;
      c_cos <= cfg_cos;
      c_sin <= cfg_sin;
    end
  end

  // Frame sequencing, beat index and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      live    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      live    <= 1'b1;
      done    <= (state == S_DRAIN) & xfer_last;
      cfg_err <= cfg_load & (state != S_IDLE);
      if (acc) idx <= idx + NUM_QUBITS'(1);
      case (state)
        S_IDLE:  if (acc) state <= S_RUN;
        S_RUN:   if (acc && idx == IDX_LAST) state <= S_DRAIN;
        S_DRAIN: if (xfer_last) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Three pipeline stages, all advancing together on adv.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s1_ap     <= 1'b0;
      s1_last   <= 1'b0;
      s1_re     <= '0;
      s1_im     <= '0;
      s1_rc     <= '0;
      s1_is     <= '0;
      s1_rs     <= '0;
      s1_ic     <= '0;
      s2_v      <= 1'b0;
      s2_ap     <= 1'b0;
      s2_last   <= 1'b0;
      s2_re     <= '0;
      s2_im     <= '0;
      s2_sr     <= '0;
      s2_si     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else if (adv) begin
      s1_v    <= acc;
      s1_ap   <= apply;
      s1_last <= acc & (idx == IDX_LAST);
      s1_re   <= in_re;
      s1_im   <= in_im;
      s1_rc   <= PW'($signed(in_re)) * PW'(e_cos);
      s1_is   <= PW'($signed(in_im)) * PW'(e_sin);
      s1_rs   <= PW'($signed(in_re)) * PW'(e_sin);
      s1_ic   <= PW'($signed(in_im)) * PW'(e_cos);

      s2_v    <= s1_v;
      s2_ap   <= s1_ap;
      s2_last <= s1_last;
      s2_re   <= s1_re;
      s2_im   <= s1_im;
      s2_sr   <= {s1_rc[PW-1], s1_rc} - {s1_is[PW-1], s1_is} + RNDV;
      s2_si   <= {s1_rs[PW-1], s1_rs} + {s1_ic[PW-1], s1_ic} + RNDV;

      out_valid <= s2_v;
      out_last  <= s2_last;
      out_re    <= s2_ap ? fit(s2_sr) : s2_re;
      out_im    <= s2_ap ? fit(s2_si) : s2_im;
    end
  end

endmodule

// File: tb/tb_gate_phase_stream.sv
// tb_gate_phase_stream: directed + random frames against a scoreboard.
// Two DUTs share stimulus: round/saturate and truncate/wrap builds.
module tb_gate_phase_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cfg_load, cfg_ctrl_en;
  logic [1:0]  cfg_target, cfg_ctrl;
  logic [15:0] cfg_cos, cfg_sin, in_re, in_im;
  logic        in_valid, out_ready;

  logic        cfg_err, in_ready, out_valid, out_last, busy, done;
  logic [15:0] out_re, out_im;
  logic        cfg_err_n, in_ready_n, out_valid_n, out_last_n;
  logic        busy_n, done_n;
  logic [15:0] out_re_n, out_im_n;

  gate_phase_stream dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load),
    .cfg_target(cfg_target), .cfg_ctrl(cfg_ctrl),
    .cfg_ctrl_en(cfg_ctrl_en), .cfg_cos(cfg_cos), .cfg_sin(cfg_sin),
    .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid),
    .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_last(out_last), .busy(busy), .done(done)
  );

  gate_phase_stream #(.ROUND(0), .SAT(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load),
    .cfg_target(cfg_target), .cfg_ctrl(cfg_ctrl),
    .cfg_ctrl_en(cfg_ctrl_en), .cfg_cos(cfg_cos), .cfg_sin(cfg_sin),
    .cfg_err(cfg_err_n), .in_valid(in_valid), .in_ready(in_ready_n),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid_n),
    .out_ready(out_ready), .out_re(out_re_n), .out_im(out_im_n),
    .out_last(out_last_n), .busy(busy_n), .done(done_n)
  );

  typedef struct {
    logic [15:0] r1, i1, r2, i2;
    logic        last;
  } exp_t;

  exp_t q[$];
  int passed = 0;
  int total  = 0;
  bit bp = 0;
  int gap = 0;

  int m_tgt, m_ctl;
  bit m_cen;
  logic signed [15:0] m_cos, m_sin;
  logic [3:0] bidx;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] fix(input longint acc,
                                      input bit rnd,
                                      input bit sat);
    longint v;
    v = acc;
    if (rnd) v = v + 16384;
    v = v >>> 15;
    if (sat && v > 32767) v = 32767;
    if (sat && v < -32768) v = -32768;
    return v[15:0];
  endfunction

  task automatic push(input logic signed [15:0] re,
                      input logic signed [15:0] im);
    exp_t e;
    bit ap;
    longint ar, ai;
    ap = bidx[m_tgt] & (!m_cen | bidx[m_ctl]);
    ar = longint'(re) * m_cos - longint'(im) * m_sin;
    ai = longint'(re) * m_sin + longint'(im) * m_cos;
    e.r1 = ap ? fix(ar, 1, 1) : re;
    e.i1 = ap ? fix(ai, 1, 1) : im;
    e.r2 = ap ? fix(ar, 0, 0) : re;
    e.i2 = ap ? fix(ai, 0, 0) : im;
    e.last = (bidx == 4'd15);
    q.push_back(e);
    bidx = bidx + 4'd1;
  endtask

  task automatic cfg(input int tg, input int ct, input bit ce,
                     input logic [15:0] c, input logic [15:0] s);
    cfg_target = tg[1:0];
    cfg_ctrl = ct[1:0];
    cfg_ctrl_en = ce;
    cfg_cos = c;
    cfg_sin = s;
    cfg_load = 1'b1;
    m_tgt = tg;
    m_ctl = ct;
    m_cen = ce;
    m_cos = c;
    m_sin = s;
  endtask

  task automatic send(input logic [15:0] re, input logic [15:0] im);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_re = re;
    in_im = im;
    for (int n = 0; n < 1000 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        push(re, im);
        ok = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    cfg_load = 1'b0;
    chk("send_accept", 32'(ok), 1);
    if (gap > 0)
      repeat ($urandom_range(0, gap)) begin
        @(posedge clk);
        #1;
      end
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (q.size() != 0 && n < 3000);
    #1;
    chk("drain_empty", q.size(), 0);
  endtask

  // Randomised downstream ready while backpressure is enabled.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboard: compare every transferred beat of both DUTs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        chk("q_nonempty", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("re_sat", out_re, e.r1);
          chk("im_sat", out_im, e.i1);
          chk("last", out_last, e.last);
          chk("valid_wrap", out_valid_n, 1);
          chk("re_wrap", out_re_n, e.r2);
          chk("im_wrap", out_im_n, e.i2);
        end
      end
    end
  end

  initial begin
    logic [15:0] cs;
    bit seen;
    rst_n = 1'b0;
    cfg_load = 1'b0;
    cfg_target = '0;
    cfg_ctrl = '0;
    cfg_ctrl_en = 1'b0;
    cfg_cos = '0;
    cfg_sin = '0;
    in_valid = 1'b0;
    in_re = '0;
    in_im = '0;
    m_tgt = 0;
    m_ctl = 0;
    m_cen = 0;
    m_cos = 16'sd32767;
    m_sin = 16'sd0;
    bidx = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_re", out_re, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", cfg_err, 0);
    rst_n = 1'b1;

    // pi/2 on target 0, latency and done timing
    cfg(0, 0, 0, 16'd0, 16'd32767);
    send(16'd16384, 16'd0);
    chk("lat_c1", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_c2", out_valid, 0);
    chk("busy_run", busy, 1);
    @(posedge clk); #1;
    chk("lat_c3", out_valid, 1);
    for (int i = 1; i < 16; i++) send(16'd16384, 16'd0);
    seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      seen = out_valid & out_ready & out_last;
    end
    chk("last_seen", 32'(seen), 1);
    @(posedge clk); #1;
    chk("done_pulse", done, 1);
    chk("busy_off", busy, 0);
    @(posedge clk); #1;
    chk("done_clear", done, 0);
    wait_empty();

    // controlled negation with backpressure and gaps
    bp = 1;
    gap = 2;
    cfg(0, 1, 1, 16'h8000, 16'd0);
    for (int i = 0; i < 16; i++)
      send(16'(1000 * i - 7000), 16'(300 - 50 * i));
    wait_empty();

    // saturate vs wrap on -1 * -1
    cfg(0, 0, 0, 16'h8000, 16'd0);
    for (int i = 0; i < 16; i++) send(16'h8000, 16'h8000);
    wait_empty();

    // rounding vs truncation on +/-3 * 0.5
    cfg(0, 0, 0, 16'd16384, 16'd0);
    for (int i = 0; i < 16; i++)
      send((i % 4 < 2) ? 16'd3 : 16'hfffd, 16'(i * 7 - 40));
    wait_empty();

    // random frames, mid-frame cfg_load ignored
    gap = 3;
    for (int f = 0; f < 2; f++) begin
      cfg($urandom_range(0, 3), $urandom_range(0, 3),
          1'($urandom_range(0, 1)),
          16'($urandom), 16'($urandom));
      for (int i = 0; i < 16; i++) begin
        send(16'($urandom), 16'($urandom));
        if (i == 5) begin
          cs = 16'($urandom);
          cfg_cos = cs;
          cfg_sin = ~cs;
          cfg_load = 1'b1;
          @(posedge clk); #1;
          cfg_load = 1'b0;
          chk("cfg_err_pulse", cfg_err, 1);
          @(posedge clk); #1;
          chk("cfg_err_clear", cfg_err, 0);
        end
      end
      wait_empty();
    end

    // reset mid-frame, then a frame on the identity config
    bp = 0;
    gap = 0;
    cfg(1, 0, 0, 16'd12345, 16'hf752);
    for (int i = 0; i < 5; i++) send(16'(i * 999), 16'(-i * 77));
    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_re", out_re, 0);
    chk("mid_rst_im", out_im, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_ready_n", in_ready_n, 0);
    chk("mid_rst_busy_n", busy_n, 0);
    chk("mid_rst_flags_n", {done_n, cfg_err_n, out_last_n}, 0);
    q.delete();
    bidx = '0;
    m_tgt = 0;
    m_ctl = 0;
    m_cen = 0;
    m_cos = 16'sd32767;
    m_sin = 16'sd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++)
      send(16'(16384 + i), 16'(-16384 - i));
    wait_empty();

    chk("final_queue", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
